// File: rtl/systolic_array_ctrl_if.sv
// Host-side streams of the systolic array job sequencer.
// cfg: job weights/len, in: input vectors, out: aligned results.
interface systolic_array_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 5
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [DATA_WIDTH-1:0] cfg_w00;
  logic [DATA_WIDTH-1:0] cfg_w01;
  logic [DATA_WIDTH-1:0] cfg_w10;
  logic [DATA_WIDTH-1:0] cfg_w11;
  logic [LEN_WIDTH-1:0]  cfg_len;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_x0;
  logic [DATA_WIDTH-1:0] in_x1;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_y0;
  logic [DATA_WIDTH-1:0] out_y1;

  modport master (
    output cfg_valid, cfg_w00, cfg_w01,
    output cfg_w10, cfg_w11, cfg_len,
    output in_valid, in_x0, in_x1,
    input  cfg_ready, in_ready,
    input  out_valid, out_y0, out_y1
  );

  modport slave (
    input  cfg_valid, cfg_w00, cfg_w01,
    input  cfg_w10, cfg_w11, cfg_len,
    input  in_valid, in_x0, in_x1,
    output cfg_ready, in_ready,
    output out_valid, out_y0, out_y1
  );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for a 2x2 weight-stationary systolic array.
// Ports: clk/reset, host (cfg/in/out streams), arr_* array pins, busy, done.
module systolic_array_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  systolic_array_ctrl_if.slave  host,
  output logic                  arr_load_weights,
  output logic                  arr_start,
  output logic [DATA_WIDTH-1:0] arr_w00,
  output logic [DATA_WIDTH-1:0] arr_w01,
  output logic [DATA_WIDTH-1:0] arr_w10,
  output logic [DATA_WIDTH-1:0] arr_w11,
  output logic [DATA_WIDTH-1:0] arr_x0,
  output logic [DATA_WIDTH-1:0] arr_x1,
  input  logic [DATA_WIDTH-1:0] arr_y0,
  input  logic [DATA_WIDTH-1:0] arr_y1,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic                  cfg_ready;
  logic                  in_ready;
  logic                  cfg_hs;
  logic                  in_hs;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  cnt;
  logic [LEN_WIDTH-1:0]  cnt_inc;
  logic [DATA_WIDTH-1:0] x1_d;
  logic [3:0]            tag;
  logic [DATA_WIDTH-1:0] hold_y0;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_y0;
  logic [DATA_WIDTH-1:0] out_y1;

  assign cfg_hs  = host.cfg_valid & cfg_ready;
  assign in_hs   = host.in_valid & in_ready;
  assign cnt_inc = cnt + 1'b1;

  assign host.cfg_ready = cfg_ready;
  assign host.in_ready  = in_ready;
  assign host.out_valid = out_valid;
  assign host.out_y0    = out_y0;
  assign host.out_y1    = out_y1;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n          = state;
    cfg_ready        = 1'b0;
    in_ready         = 1'b0;
    arr_load_weights = 1'b0;
    arr_start        = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy      = 1'b0;
        cfg_ready = 1'b1;
        if (host.cfg_valid) state_n = S_LOAD;
      end
      S_LOAD: begin
        arr_load_weights = 1'b1;
        if (len_q == '0) state_n = S_DONE;
        else             state_n = S_STREAM;
      end
      S_STREAM: begin
        arr_start = 1'b1;
        in_ready  = (cnt < len_q);
        if (in_hs && cnt_inc == len_q)
          state_n = S_DRAIN;
      end
      S_DRAIN: begin
        arr_start = 1'b1;
        // tag[3] feeds out_valid, so an empty
        // pipe means the last beat is out now.
        if (tag == '0) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q   <= '0;
      cnt     <= '0;
      arr_w00 <= '0;
      arr_w01 <= '0;
      arr_w10 <= '0;
      arr_w11 <= '0;
    end else begin
      if (cfg_hs) begin
        len_q   <= host.cfg_len;
        cnt     <= '0;
        arr_w00 <= host.cfg_w00;
        arr_w01 <= host.cfg_w01;
        arr_w10 <= host.cfg_w10;
        arr_w11 <= host.cfg_w11;
      end else if (in_hs) begin
        cnt <= cnt_inc;
      end
    end
  end

  // Row skew: x1 trails x0 by one slot.
  // Bubbles push zeros and a 0 tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      arr_x0 <= '0;
      x1_d   <= '0;
      arr_x1 <= '0;
      tag    <= '0;
    end else begin
      arr_x0 <= in_hs ? host.in_x0 : '0;
      x1_d   <= in_hs ? host.in_x1 : '0;
      arr_x1 <= x1_d;
      tag    <= {tag[2:0], in_hs};
    end
  end

  // De-skew: y0 is ready one cycle before y1.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_y0   <= '0;
      out_valid <= 1'b0;
      out_y0    <= '0;
      out_y1    <= '0;
    end else begin
      if (tag[2]) hold_y0 <= arr_y0;
      out_valid <= tag[3];
      if (tag[3]) begin
        out_y0 <= hold_y0;
        out_y1 <= arr_y1;
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl with a behavioural 2x2 array.
// Job table drives cfg/in streams; scoreboard checks beats and timing.
module tb_systolic_array_ctrl;
  localparam int DW = 8;
  localparam int LW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_array_ctrl_if #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW)
  ) bus ();

  logic          arr_load_weights, arr_start;
  logic [DW-1:0] arr_w00, arr_w01, arr_w10, arr_w11;
  logic [DW-1:0] arr_x0, arr_x1, arr_y0, arr_y1;
  logic          busy, done;

  systolic_array_ctrl #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .host             (bus),
    .arr_load_weights (arr_load_weights),
    .arr_start        (arr_start),
    .arr_w00          (arr_w00),
    .arr_w01          (arr_w01),
    .arr_w10          (arr_w10),
    .arr_w11          (arr_w11),
    .arr_x0           (arr_x0),
    .arr_x1           (arr_x1),
    .arr_y0           (arr_y0),
    .arr_y1           (arr_y1),
    .busy             (busy),
    .done             (done)
  );

  // Behavioural array: PE regs update when start is high.
  logic [DW-1:0] p00_in, p00_ps, p01_ps;
  logic [DW-1:0] p10_in, p10_ps, p11_ps;
  always @(posedge clk) begin
    if (reset) begin
      p00_in <= '0; p00_ps <= '0; p01_ps <= '0;
      p10_in <= '0; p10_ps <= '0; p11_ps <= '0;
    end else if (arr_start) begin
      p00_in <= arr_x0;
      p00_ps <= arr_w00 * arr_x0;
      p01_ps <= arr_w01 * p00_in;
      p10_in <= arr_x1;
      p10_ps <= p00_ps + arr_w10 * arr_x1;
      p11_ps <= p01_ps + arr_w11 * p10_in;
    end
  end
  assign arr_y0 = p10_ps;
  assign arr_y1 = p11_ps;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int y0;
    int y1;
  } beat_t;
  beat_t beats[$];
  int n_done = 0;
  always @(negedge clk) begin
    if (bus.out_valid)
      beats.push_back('{cyc, bus.out_y0, bus.out_y1});
    if (done) n_done++;
  end

  typedef struct {
    int         w[4];
    int         len;
    logic [7:0] pat;
    int         x0[4];
    int         x1[4];
    int         ey0[4];
    int         ey1[4];
  } job_t;
  job_t jobs[8];

  int n_vec = 0;
  int n_err = 0;
  int last_done = -1;

  task automatic chk(input string name,
                     input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d @cyc %0d",
               name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int j, input int a,
                         input int b, input int c,
                         input int d, input int len,
                         input logic [7:0] pat);
    jobs[j].w[0] = a; jobs[j].w[1] = b;
    jobs[j].w[2] = c; jobs[j].w[3] = d;
    jobs[j].len = len;
    jobs[j].pat = pat;
  endtask

  task automatic set_vec(input int j, input int i,
                         input int x0, input int x1,
                         input int y0, input int y1);
    jobs[j].x0[i] = x0; jobs[j].x1[i] = x1;
    jobs[j].ey0[i] = y0; jobs[j].ey1[i] = y1;
  endtask

  task automatic drive_cfg(input int j);
    bus.cfg_valid = 1'b1;
    bus.cfg_w00 = DW'(jobs[j].w[0]);
    bus.cfg_w01 = DW'(jobs[j].w[1]);
    bus.cfg_w10 = DW'(jobs[j].w[2]);
    bus.cfg_w11 = DW'(jobs[j].w[3]);
    bus.cfg_len = LW'(jobs[j].len);
  endtask

  task automatic run_job(input int j, input int exp_k,
                         input bit hold, input int nj);
    int k, m, i, p, t, len;
    int hs_c[4];
    logic v;
    len = jobs[j].len;
    beats.delete();
    drive_cfg(j);
    t = 0;
    while (!bus.cfg_ready && t < 50) begin
      step(); t++;
    end
    chk("cfg_accept", bus.cfg_ready, 1);
    k = cyc;
    if (exp_k >= 0) chk("cfg_at_done_plus1", k, exp_k);
    step();
    if (hold) drive_cfg(nj);
    else bus.cfg_valid = 1'b0;
    chk("load_pulse", arr_load_weights, 1);
    chk("start_in_load", arr_start, 0);
    chk("w00_latched", arr_w00, jobs[j].w[0]);
    chk("w11_latched", arr_w11, jobs[j].w[3]);
    step();
    if (len == 0) begin
      chk("done_len0", done, 1);
      chk("busy_len0", busy, 1);
      chk("start_len0", arr_start, 0);
      chk("in_ready_len0", bus.in_ready, 0);
      last_done = cyc;
      step();
      chk("cfg_ready_len0", bus.cfg_ready, 1);
      chk("beats_len0", beats.size(), 0);
      return;
    end
    chk("first_in_ready", bus.in_ready, 1);
    i = 0; p = 0; t = 0; m = k;
    while (i < len && t < 100) begin
      v = (p < 8) ? jobs[j].pat[p] : 1'b1;
      bus.in_valid = v;
      bus.in_x0 = DW'(jobs[j].x0[i]);
      bus.in_x1 = DW'(jobs[j].x1[i]);
      if (v && bus.in_ready) begin
        hs_c[i] = cyc;
        m = cyc;
        i++;
      end
      p++; t++;
      step();
    end
    bus.in_valid = 1'b0;
    chk("all_accepted", i, len);
    chk("in_ready_drop", bus.in_ready, 0);
    t = 0;
    while (!done && t < 30) begin
      step(); t++;
    end
    chk("done_cycle", cyc, m + 6);
    chk("w00_held", arr_w00, jobs[j].w[0]);
    last_done = cyc;
    step();
    chk("cfg_ready_after", bus.cfg_ready, 1);
    chk("busy_after", busy, 0);
    chk("beat_count", beats.size(), len);
    for (int b = 0; b < len && b < beats.size(); b++) begin
      chk("beat_latency", beats[b].c, hs_c[b] + 5);
      chk("beat_y0", beats[b].y0, jobs[j].ey0[b]);
      chk("beat_y1", beats[b].y1, jobs[j].ey1[b]);
    end
  endtask

  task automatic reset_mid_job();
    int t, nd;
    beats.delete();
    drive_cfg(1);
    bus.cfg_len = LW'(4);
    t = 0;
    while (!bus.cfg_ready && t < 50) begin
      step(); t++;
    end
    step();
    bus.cfg_valid = 1'b0;
    step();
    bus.in_valid = 1'b1;
    bus.in_x0 = 8'd1; bus.in_x1 = 8'd1;
    step();
    bus.in_x0 = 8'd2; bus.in_x1 = 8'd3;
    step();
    bus.in_valid = 1'b0;
    chk("stream_before_rst", arr_start, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_load", arr_load_weights, 0);
    chk("rst_start", arr_start, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x0", arr_x0, 0);
    chk("rst_x1", arr_x1, 0);
    chk("rst_w01", arr_w01, 0);
    chk("rst_cfg_ready", bus.cfg_ready, 1);
    nd = n_done;
    repeat (10) step();
    chk("rst_no_beats", beats.size(), 0);
    chk("rst_no_done", n_done, nd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    set_job(0, 1, 2, 3, 4, 1, 8'hFF);
    set_vec(0, 0, 1, 1, 4, 6);
    set_job(1, 1, 2, 3, 4, 3, 8'hFF);
    set_vec(1, 0, 1, 1, 4, 6);
    set_vec(1, 1, 2, 3, 11, 16);
    set_vec(1, 2, 0, 5, 15, 20);
    set_job(2, 1, 2, 3, 4, 4, 8'b1101_1001);
    set_vec(2, 0, 1, 0, 1, 2);
    set_vec(2, 1, 0, 1, 3, 4);
    set_vec(2, 2, 3, 3, 12, 18);
    set_vec(2, 3, 255, 1, 2, 2);
    set_job(3, 9, 9, 9, 9, 0, 8'hFF);
    set_job(4, 16, 1, 2, 3, 1, 8'hFF);
    set_vec(4, 0, 16, 0, 0, 16);
    set_job(5, 5, 6, 7, 8, 2, 8'hFF);
    set_vec(5, 0, 1, 1, 12, 14);
    set_vec(5, 1, 2, 0, 10, 12);
    set_job(6, 1, 1, 1, 1, 1, 8'hFF);
    set_vec(6, 0, 2, 2, 4, 4);

    reset = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_w00 = '0; bus.cfg_w01 = '0;
    bus.cfg_w10 = '0; bus.cfg_w11 = '0;
    bus.cfg_len = '0;
    bus.in_valid = 1'b0;
    bus.in_x0 = '0; bus.in_x1 = '0;
    step(); step();
    chk("init_out_valid", bus.out_valid, 0);
    chk("init_out_y0", bus.out_y0, 0);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_w00", arr_w00, 0);
    chk("init_cfg_ready", bus.cfg_ready, 1);
    reset = 1'b0;
    step();

    run_job(0, -1, 1'b0, 0);
    run_job(1, -1, 1'b0, 0);
    run_job(2, -1, 1'b0, 0);
    run_job(3, -1, 1'b0, 0);
    reset_mid_job();
    run_job(6, -1, 1'b0, 0);
    run_job(4, -1, 1'b1, 5);
    run_job(5, last_done + 1, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
